// File: rtl/rs_station.sv
// Reservation station: holds issued instructions until both operands are
// present (captured at issue, by same-cycle CDB bypass, or by CDB snoop),
// then hands the oldest ready entry to the functional unit through a
// registered dispatch stage.
//
// Handshakes: a transfer on the issue side happens on a rising edge where
// in_valid && in_ready && !flush; on the FU side on an edge where
// fu_valid && fu_ready. in_ready depends only on registered state, so a
// slot freed by dispatch becomes allocatable one cycle later.
module rs_station #(
  parameter int DEPTH    = 3,
  parameter int XLEN     = 64,
  parameter int TAG_W    = 4,
  parameter int BASE_TAG = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [TAG_W-1:0]             alloc_tag,
  input  logic [5:0]                   in_opcode,
  input  logic [TAG_W-1:0]             in_tag1,
  input  logic [TAG_W-1:0]             in_tag2,
  input  logic [XLEN-1:0]              in_op1,
  input  logic [XLEN-1:0]              in_op2,
  input  logic [XLEN-1:0]              in_incr_pc,
  input  logic [XLEN-1:0]              in_offset,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [XLEN-1:0]              cdb_data,
  output logic                         fu_valid,
  input  logic                         fu_ready,
  output logic [XLEN-1:0]              fu_a,
  output logic [XLEN-1:0]              fu_b,
  output logic [XLEN-1:0]              fu_incr_pc,
  output logic [XLEN-1:0]              fu_offset,
  output logic [5:0]                   fu_opcode,
  output logic [TAG_W-1:0]             fu_tag,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  // Entry storage
  logic [DEPTH-1:0] ent_valid;
  logic [5:0]       ent_opcode [DEPTH];
  logic [TAG_W-1:0] ent_tag1   [DEPTH];
  logic [TAG_W-1:0] ent_tag2   [DEPTH];
  logic [XLEN-1:0]  ent_op1    [DEPTH];
  logic [XLEN-1:0]  ent_op2    [DEPTH];
  logic [XLEN-1:0]  ent_pc     [DEPTH];
  logic [XLEN-1:0]  ent_off    [DEPTH];
  // older[j][i] = 1 when entry j was accepted before entry i. Stale bits of
  // freed entries are harmless because only ready (valid) entries are compared.
  logic [DEPTH-1:0] older      [DEPTH];

  logic             free_found;
  logic [IW-1:0]    free_idx;
  logic [CW-1:0]    occ;
  logic [DEPTH-1:0] ent_ready;
  logic             blocked;
  logic             sel_found;
  logic [IW-1:0]    sel_idx;
  logic [XLEN-1:0]  sel_a, sel_b, sel_pc, sel_off;
  logic [5:0]       sel_opcode;
  logic [TAG_W-1:0] sel_tag;
  logic             accept;
  logic             disp_en;
  logic             hit1, hit2;
  logic [TAG_W-1:0] new_tag1, new_tag2;
  logic [XLEN-1:0]  new_op1, new_op2;

  // Lowest free slot and occupancy, from registered valids only
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    occ        = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + CW'(ent_valid[i]);
    end
  end

  // Oldest ready entry: the ready entry that no other ready entry predates
  always_comb begin
    ent_ready  = '0;
    blocked    = 1'b0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_a      = '0;
    sel_b      = '0;
    sel_pc     = '0;
    sel_off    = '0;
    sel_opcode = '0;
    sel_tag    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_ready[i] = ent_valid[i] && (ent_tag1[i] == '0) && (ent_tag2[i] == '0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (ent_ready[j] && older[j][i]) blocked = 1'b1;
      end
      if (ent_ready[i] && !blocked) begin
        sel_found  = 1'b1;
        sel_idx    = IW'(i);
        sel_a      = ent_op1[i];
        sel_b      = ent_op2[i];
        sel_pc     = ent_pc[i];
        sel_off    = ent_off[i];
        sel_opcode = ent_opcode[i];
        sel_tag    = TAG_W'(BASE_TAG + i);
      end
    end
  end

  // Issue-side operand capture including same-cycle CDB bypass
  always_comb begin
    hit1     = cdb_valid && (in_tag1 != '0) && (in_tag1 == cdb_tag);
    hit2     = cdb_valid && (in_tag2 != '0) && (in_tag2 == cdb_tag);
    new_tag1 = hit1 ? '0 : in_tag1;
    new_tag2 = hit2 ? '0 : in_tag2;
    new_op1  = hit1 ? cdb_data : in_op1;
    new_op2  = hit2 ? cdb_data : in_op2;
  end

  assign accept    = in_valid && free_found && !flush;
  assign disp_en   = sel_found && (!fu_valid || fu_ready) && !flush;
  assign in_ready  = free_found;
  assign busy      = !free_found;
  assign count     = occ;
  assign alloc_tag = free_found ? (TAG_W'(BASE_TAG) + TAG_W'(free_idx)) : '0;

  // Entry array: flush, snoop, free on dispatch, allocate, age tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_opcode[i] <= '0;
        ent_tag1[i]   <= '0;
        ent_tag2[i]   <= '0;
        ent_op1[i]    <= '0;
        ent_op2[i]    <= '0;
        ent_pc[i]     <= '0;
        ent_off[i]    <= '0;
        older[i]      <= '0;
      end
    end else if (flush) begin
      ent_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && cdb_valid && (ent_tag1[i] != '0) && (ent_tag1[i] == cdb_tag)) begin
          ent_tag1[i] <= '0;
          ent_op1[i]  <= cdb_data;
        end
        if (ent_valid[i] && cdb_valid && (ent_tag2[i] != '0) && (ent_tag2[i] == cdb_tag)) begin
          ent_tag2[i] <= '0;
          ent_op2[i]  <= cdb_data;
        end
        if (disp_en && (sel_idx == IW'(i))) begin
          ent_valid[i] <= 1'b0;
        end
        if (accept && (free_idx == IW'(i))) begin
          ent_valid[i]  <= 1'b1;
          ent_opcode[i] <= in_opcode;
          ent_tag1[i]   <= new_tag1;
          ent_tag2[i]   <= new_tag2;
          ent_op1[i]    <= new_op1;
          ent_op2[i]    <= new_op2;
          ent_pc[i]     <= in_incr_pc;
          ent_off[i]    <= in_offset;
        end
        for (int j = 0; j < DEPTH; j++) begin
          if (accept && (free_idx == IW'(j))) begin
            older[i][j] <= (i != j) && ent_valid[i];
          end else if (accept && (free_idx == IW'(i))) begin
            older[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  // Dispatch register: load when empty or draining, hold while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fu_valid   <= 1'b0;
      fu_a       <= '0;
      fu_b       <= '0;
      fu_incr_pc <= '0;
      fu_offset  <= '0;
      fu_opcode  <= '0;
      fu_tag     <= '0;
    end else if (flush) begin
      fu_valid <= 1'b0;
    end else if (disp_en) begin
      fu_valid   <= 1'b1;
      fu_a       <= sel_a;
      fu_b       <= sel_b;
      fu_incr_pc <= sel_pc;
      fu_offset  <= sel_off;
      fu_opcode  <= sel_opcode;
      fu_tag     <= sel_tag;
    end else if (fu_ready) begin
      fu_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Bench for rs_station: directed issue/CDB/flush/reset scenarios, a
// sequence-number behavioural model compared every cycle, and literal
// expectations at the key points of each scenario.
module tb_rs_station;

  localparam int DEPTH    = 3;
  localparam int XLEN     = 64;
  localparam int TAG_W    = 4;
  localparam int BASE_TAG = 1;
  localparam int CW       = $clog2(DEPTH+1);

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             flush, in_valid, in_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic [5:0]       in_opcode;
  logic [TAG_W-1:0] in_tag1, in_tag2;
  logic [XLEN-1:0]  in_op1, in_op2, in_incr_pc, in_offset;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;
  logic             fu_valid, fu_ready;
  logic [XLEN-1:0]  fu_a, fu_b, fu_incr_pc, fu_offset;
  logic [5:0]       fu_opcode;
  logic [TAG_W-1:0] fu_tag;
  logic [CW-1:0]    count;
  logic             busy;

  rs_station #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .BASE_TAG(BASE_TAG)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .alloc_tag(alloc_tag),
    .in_opcode(in_opcode), .in_tag1(in_tag1), .in_tag2(in_tag2),
    .in_op1(in_op1), .in_op2(in_op2), .in_incr_pc(in_incr_pc), .in_offset(in_offset),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_a(fu_a), .fu_b(fu_b), .fu_incr_pc(fu_incr_pc), .fu_offset(fu_offset),
    .fu_opcode(fu_opcode), .fu_tag(fu_tag), .count(count), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: entries carry an acceptance sequence number
  bit               m_valid [DEPTH];
  logic [5:0]       m_opc   [DEPTH];
  logic [TAG_W-1:0] m_t1    [DEPTH];
  logic [TAG_W-1:0] m_t2    [DEPTH];
  logic [XLEN-1:0]  m_a     [DEPTH];
  logic [XLEN-1:0]  m_b     [DEPTH];
  logic [XLEN-1:0]  m_pc    [DEPTH];
  logic [XLEN-1:0]  m_off   [DEPTH];
  int               m_seq   [DEPTH];
  int               m_next_seq;
  bit               mf_valid;
  logic [XLEN-1:0]  mf_a, mf_b, mf_pc, mf_off;
  logic [5:0]       mf_opc;
  logic [TAG_W-1:0] mf_tag;
  bit               m_loaded;
  logic [TAG_W-1:0] exp_q[$];

  function automatic int model_free_idx();
    int lf = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[i]) lf = i;
    return lf;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    mf_valid = 1'b0; mf_a = '0; mf_b = '0; mf_pc = '0; mf_off = '0;
    mf_opc = '0; mf_tag = '0; m_loaded = 1'b0; m_next_seq = 0;
    exp_q.delete();
  endtask

  // One clock edge of the model, using the inputs held across the edge
  task automatic model_step();
    int lf, best;
    m_loaded = 1'b0;
    if (rst) begin model_reset(); return; end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      mf_valid = 1'b0;
      exp_q.delete();
      return;
    end
    lf = model_free_idx();
    best = -1;
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && m_t1[i] == 0 && m_t2[i] == 0 && (best < 0 || m_seq[i] < m_seq[best]))
        best = i;
    if (best >= 0 && (!mf_valid || fu_ready)) begin
      mf_valid = 1'b1; mf_a = m_a[best]; mf_b = m_b[best]; mf_pc = m_pc[best];
      mf_off = m_off[best]; mf_opc = m_opc[best]; mf_tag = TAG_W'(BASE_TAG + best);
      m_valid[best] = 1'b0;
      m_loaded = 1'b1;
      exp_q.push_back(mf_tag);
    end else if (fu_ready) begin
      mf_valid = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && cdb_valid && m_t1[i] != 0 && m_t1[i] == cdb_tag) begin m_t1[i] = 0; m_a[i] = cdb_data; end
      if (m_valid[i] && cdb_valid && m_t2[i] != 0 && m_t2[i] == cdb_tag) begin m_t2[i] = 0; m_b[i] = cdb_data; end
    end
    if (in_valid && lf >= 0) begin
      m_valid[lf] = 1'b1; m_opc[lf] = in_opcode; m_pc[lf] = in_incr_pc; m_off[lf] = in_offset;
      m_t1[lf] = in_tag1; m_a[lf] = in_op1; m_t2[lf] = in_tag2; m_b[lf] = in_op2;
      if (cdb_valid && in_tag1 != 0 && in_tag1 == cdb_tag) begin m_t1[lf] = 0; m_a[lf] = cdb_data; end
      if (cdb_valid && in_tag2 != 0 && in_tag2 == cdb_tag) begin m_t2[lf] = 0; m_b[lf] = cdb_data; end
      m_seq[lf] = m_next_seq;
      m_next_seq++;
    end
  endtask

  // Scoreboard compare on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      int lf;
      lf = model_free_idx();
      chk("m_in_ready", in_ready, lf >= 0);
      chk("m_busy", busy, lf < 0);
      chk("m_count", count, model_count());
      chk("m_alloc_tag", alloc_tag, (lf >= 0) ? BASE_TAG + lf : 0);
      chk("m_fu_valid", fu_valid, mf_valid);
      if (mf_valid) begin
        chk("m_fu_a", fu_a, mf_a);
        chk("m_fu_b", fu_b, mf_b);
        chk("m_fu_incr_pc", fu_incr_pc, mf_pc);
        chk("m_fu_offset", fu_offset, mf_off);
        chk("m_fu_opcode", fu_opcode, mf_opc);
        chk("m_fu_tag", fu_tag, mf_tag);
      end
      if (m_loaded && exp_q.size() > 0) chk("order", fu_tag, exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic issue(input logic [5:0] opc, input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    in_valid = 1'b1; in_opcode = opc; in_tag1 = t1; in_tag2 = t2;
    in_op1 = a; in_op2 = b;
    in_incr_pc = 64'h1000 + XLEN'(opc); in_offset = 64'h2000 + XLEN'(opc);
  endtask

  task automatic cdb(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
  endtask

  task automatic check_reset_values(input string tagname);
    chk({tagname, "_fu_valid"}, fu_valid, 0);
    chk({tagname, "_fu_a"}, fu_a, 0);
    chk({tagname, "_fu_b"}, fu_b, 0);
    chk({tagname, "_fu_incr_pc"}, fu_incr_pc, 0);
    chk({tagname, "_fu_offset"}, fu_offset, 0);
    chk({tagname, "_fu_opcode"}, fu_opcode, 0);
    chk({tagname, "_fu_tag"}, fu_tag, 0);
    chk({tagname, "_count"}, count, 0);
    chk({tagname, "_busy"}, busy, 0);
    chk({tagname, "_in_ready"}, in_ready, 1);
    chk({tagname, "_alloc_tag"}, alloc_tag, BASE_TAG);
  endtask

  // Time limit
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    idle();
    fu_ready = 1'b1;
    in_opcode = '0; in_tag1 = '0; in_tag2 = '0; in_op1 = '0; in_op2 = '0;
    in_incr_pc = '0; in_offset = '0; cdb_tag = '0; cdb_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset, then issue: both operands present
    issue(6'b111001, 0, 0, 5, 7);
    tick();
    chk("t1_count_after_alloc", count, 1);
    chk("t1_fu_idle", fu_valid, 0);
    idle();
    tick();
    chk("t1_fu_valid", fu_valid, 1);
    chk("t1_fu_a", fu_a, 5);
    chk("t1_fu_b", fu_b, 7);
    chk("t1_fu_tag", fu_tag, BASE_TAG);
    chk("t1_fu_opcode", fu_opcode, 6'b111001);
    chk("t1_count", count, 0);
    tick();
    chk("t1_drained", fu_valid, 0);

    // Snoop: tag 5 ignored, tag 4 captured
    issue(2, 4, 0, 0, 3);
    tick();
    idle();
    tick();
    cdb(5, 64'h77);
    tick();
    chk("t2_tag5_no_effect", fu_valid, 0);
    chk("t2_count", count, 1);
    cdb(4, 64'hAA);
    tick();
    chk("t2_not_yet", fu_valid, 0);
    idle();
    tick();
    chk("t2_fu_valid", fu_valid, 1);
    chk("t2_fu_a", fu_a, 64'hAA);
    chk("t2_fu_b", fu_b, 3);
    chk("t2_count", count, 0);
    tick();

    // Same-cycle bypass on source 2
    issue(3, 0, 6, 64'h10, 0);
    cdb(6, 64'h55);
    tick();
    chk("t3_count", count, 1);
    idle();
    tick();
    chk("t3_fu_valid", fu_valid, 1);
    chk("t3_fu_a", fu_a, 64'h10);
    chk("t3_fu_b", fu_b, 64'h55);
    tick();

    // Oldest first with a stalled FU: expected order B, C, A
    fu_ready = 1'b0;
    issue(4, 9, 0, 0, 1);             // A, entry 0
    tick();
    issue(5, 0, 0, 64'h20, 64'h21);   // B, entry 1
    tick();
    issue(6, 0, 0, 64'h30, 64'h31);   // C, entry 2; B dispatched this edge
    tick();
    chk("t4_b_tag", fu_tag, 2);
    chk("t4_count", count, 2);
    idle();
    repeat (2) tick();
    chk("t4_hold_tag", fu_tag, 2);
    chk("t4_hold_a", fu_a, 64'h20);
    fu_ready = 1'b1;
    cdb(9, 64'h99);
    tick();
    chk("t4_c_tag", fu_tag, 3);
    chk("t4_c_a", fu_a, 64'h30);
    idle();
    tick();
    chk("t4_a_tag", fu_tag, 1);
    chk("t4_a_a", fu_a, 64'h99);
    chk("t4_a_b", fu_b, 1);
    tick();
    chk("t4_empty", count, 0);

    // Full and reuse
    fu_ready = 1'b0;
    issue(7, 7, 0, 1, 2);
    tick();
    issue(8, 8, 0, 3, 4);
    tick();
    issue(9, 7, 0, 5, 6);
    tick();
    chk("t5_in_ready", in_ready, 0);
    chk("t5_busy", busy, 1);
    chk("t5_alloc_tag", alloc_tag, 0);
    chk("t5_count", count, 3);
    in_valid = 1'b0;
    cdb(8, 64'hBB);
    tick();
    cdb_valid = 1'b0;
    issue(10, 0, 0, 64'h40, 64'h41);  // refused: station full this cycle
    tick();
    chk("t5_disp_tag", fu_tag, 2);
    chk("t5_disp_a", fu_a, 64'hBB);
    chk("t5_count_after", count, 2);
    chk("t5_ready_again", in_ready, 1);
    chk("t5_reuse_tag", alloc_tag, 2);
    tick();                           // now accepted into entry 1
    chk("t5_refill", count, 3);
    idle();
    fu_ready = 1'b1;
    cdb(7, 64'hCC);
    tick();
    chk("t5_y_a", fu_a, 64'h40);
    idle();
    tick();
    chk("t5_x1_tag", fu_tag, 1);
    chk("t5_x1_a", fu_a, 64'hCC);
    tick();
    chk("t5_x3_tag", fu_tag, 3);
    chk("t5_x3_b", fu_b, 6);
    tick();
    chk("t5_drained", fu_valid, 0);

    // Flush during a snoop with in_valid high
    fu_ready = 1'b0;
    issue(11, 0, 0, 1, 1);
    tick();
    idle();
    tick();
    chk("t6_fu_loaded", fu_valid, 1);
    issue(12, 10, 0, 0, 0);
    tick();
    issue(13, 10, 0, 0, 0);
    cdb(10, 64'hDD);
    flush = 1'b1;
    tick();
    chk("t6_count", count, 0);
    chk("t6_fu_valid", fu_valid, 0);
    chk("t6_alloc_tag", alloc_tag, BASE_TAG);
    idle();
    tick();
    chk("t6_nothing_allocated", count, 0);
    chk("t6_still_empty", fu_valid, 0);
    fu_ready = 1'b1;

    // Asynchronous reset between edges
    issue(14, 0, 0, 64'h50, 64'h51);
    tick();
    issue(15, 3, 0, 0, 0);
    tick();
    chk("t7_pre_fu_valid", fu_valid, 1);
    chk("t7_pre_count", count, 1);
    idle();
    chk_en = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_values("async");
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // Back-to-back throughput
    for (int k = 0; k < 5; k++) begin
      issue(6'(16 + k), 0, 0, 64'h100 + 64'(k), 64'h200 + 64'(k));
      tick();
      if (k > 0) chk("t8_fu_valid", fu_valid, 1);
    end
    idle();
    tick();
    chk("t8_last_a", fu_a, 64'h104);
    tick();
    chk("t8_drained", fu_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
